// File: rtl/vga_grid_renderer.sv
// VGA timing generator that renders a frame-latched cell map as a bordered grid
// with a blinking cursor; two-stage pipeline from pixel counters to colour.
module vga_grid_renderer #(
  parameter int GRID_W_MAX   = 16,
  parameter int GRID_H_MAX   = 16,
  parameter int BORDER       = 1,
  parameter int BLINK_FRAMES = 30,
  parameter int CW           = 12,
  localparam int GW_W  = $clog2(GRID_W_MAX + 1),
  localparam int GH_W  = $clog2(GRID_H_MAX + 1),
  localparam int CX_W  = $clog2(GRID_W_MAX),
  localparam int CY_W  = $clog2(GRID_H_MAX),
  localparam int MAP_N = GRID_W_MAX * GRID_H_MAX
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CW-1:0]    h_total,
  input  logic [CW-1:0]    h_sync,
  input  logic [CW-1:0]    h_start,
  input  logic [CW-1:0]    h_end,
  input  logic [CW-1:0]    v_total,
  input  logic [CW-1:0]    v_sync,
  input  logic [CW-1:0]    v_start,
  input  logic [CW-1:0]    v_end,
  input  logic [CW-1:0]    cell_w,
  input  logic [CW-1:0]    cell_h,
  input  logic [GW_W-1:0]  grid_w,
  input  logic [GH_W-1:0]  grid_h,
  input  logic [MAP_N-1:0] cell_map,
  input  logic [CX_W-1:0]  cursor_x,
  input  logic [CY_W-1:0]  cursor_y,
  output logic             frame_start,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b
);

  localparam int IDX_W = $clog2(MAP_N);
  localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [23:0] COL_BLACK  = 24'h000000;
  localparam logic [23:0] COL_FRAME  = 24'h32D8E0;
  localparam logic [23:0] COL_OUT    = 24'hFFFFFF;
  localparam logic [23:0] COL_CURSOR = 24'hFF5C39;
  localparam logic [23:0] COL_ALIVE  = 24'h12AFAF;

  localparam logic [MAP_N-1:0] MAP_ONE = MAP_N'(1);

  typedef struct packed {
    logic [MAP_N-1:0] map;
    logic [CX_W-1:0]  cur_x;
    logic [CY_W-1:0]  cur_y;
    logic [GW_W-1:0]  grid_w;
    logic [GH_W-1:0]  grid_h;
    logic [CW-1:0]    cell_w;
    logic [CW-1:0]    cell_h;
    logic             vis;
  } snap_t;

  typedef struct packed {
    logic fs;
    logic hs;
    logic vs;
    logic de;
    logic win;
    logic is_out;
    logic edge_px;
    logic cursor;
    logic alive;
  } pix_t;

  localparam pix_t PIX_RESET = '{fs: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b0, win: 1'b0,
                                 is_out: 1'b0, edge_px: 1'b0, cursor: 1'b0, alive: 1'b0};

  logic [CW-1:0]   h_count_q, h_count_d;
  logic [CW-1:0]   v_count_q, v_count_d;
  snap_t           snap_q, snap_d;
  logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_hide_q, blink_hide_d;
  logic [CW-1:0]   px_x_q, px_x_d;
  logic [CW-1:0]   py_q, py_d;
  logic [GW_W-1:0] cell_x_q, cell_x_d;
  logic [GH_W-1:0] cell_y_q, cell_y_d;
  pix_t            s1_q, s1_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            de_q, de_d;
  logic            fs_q, fs_d;

  logic             hs_raw, vs_raw, h_act, v_act, de_raw;
  logic             frame_top, line_end;
  logic [CW-1:0]    px_cur, py_cur;
  logic [GW_W-1:0]  cx_cur;
  logic [GH_W-1:0]  cy_cur;
  logic             in_grid, edge_x, edge_y, win_raw, cursor_raw, alive_raw;
  logic [IDX_W-1:0] map_idx;

  always_comb begin
    h_count_d = h_count_q + 1'b1;
    v_count_d = v_count_q;
    if (h_count_q >= h_total) begin
      h_count_d = '0;
      v_count_d = (v_count_q >= v_total) ? '0 : v_count_q + 1'b1;
    end
  end

  always_comb begin
    hs_raw    = (h_count_q >= h_sync) && (h_count_q != h_total);
    vs_raw    = (v_count_q >= v_sync) && (v_count_q != v_total);
    h_act     = (h_count_q >= h_start) && (h_count_q < h_end);
    v_act     = (v_count_q >= v_start) && (v_count_q < v_end);
    de_raw    = h_act && v_act;
    frame_top = (h_count_q == '0) && (v_count_q == '0);
    line_end  = (h_count_q >= h_total);
  end

  // The blink phase is captured with the pre-update value so frame N shows phase N.
  always_comb begin
    snap_d       = snap_q;
    blink_cnt_d  = blink_cnt_q;
    blink_hide_d = blink_hide_q;
    if (frame_top) begin
      snap_d.map    = cell_map;
      snap_d.cur_x  = cursor_x;
      snap_d.cur_y  = cursor_y;
      snap_d.grid_w = grid_w;
      snap_d.grid_h = grid_h;
      snap_d.cell_w = cell_w;
      snap_d.cell_h = cell_h;
      snap_d.vis    = ~blink_hide_q;
      if (BLINK_FRAMES > 0) begin
        if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d  = '0;
          blink_hide_d = ~blink_hide_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // Position inside the cell is counted, not divided; the registers hold the
  // value for the next pixel and are forced to zero at the start of the area.
  always_comb begin
    px_cur   = (h_count_q == h_start) ? '0 : px_x_q;
    cx_cur   = (h_count_q == h_start) ? '0 : cell_x_q;
    py_cur   = (v_count_q == v_start) ? '0 : py_q;
    cy_cur   = (v_count_q == v_start) ? '0 : cell_y_q;
    px_x_d   = px_cur;
    cell_x_d = cx_cur;
    py_d     = py_cur;
    cell_y_d = cy_cur;
    if (h_act) begin
      if (px_cur == snap_q.cell_w - 1'b1) begin
        px_x_d   = '0;
        cell_x_d = (cx_cur == GW_W'(GRID_W_MAX)) ? cx_cur : cx_cur + 1'b1;
      end else begin
        px_x_d = px_cur + 1'b1;
      end
    end
    if (line_end && v_act) begin
      if (py_cur == snap_q.cell_h - 1'b1) begin
        py_d     = '0;
        cell_y_d = (cy_cur == GH_W'(GRID_H_MAX)) ? cy_cur : cy_cur + 1'b1;
      end else begin
        py_d = py_cur + 1'b1;
      end
    end
  end

  always_comb begin
    in_grid    = (cx_cur < snap_q.grid_w) && (cy_cur < snap_q.grid_h);
    edge_x     = (snap_q.cell_w <= CW'(2 * BORDER)) || (px_cur < CW'(BORDER)) ||
                 (px_cur >= snap_q.cell_w - CW'(BORDER));
    edge_y     = (snap_q.cell_h <= CW'(2 * BORDER)) || (py_cur < CW'(BORDER)) ||
                 (py_cur >= snap_q.cell_h - CW'(BORDER));
    win_raw    = (h_count_q == h_start) || (h_count_q == h_end - 1'b1) ||
                 (v_count_q == v_start) || (v_count_q == v_end - 1'b1);
    cursor_raw = (cx_cur == GW_W'(snap_q.cur_x)) && (cy_cur == GH_W'(snap_q.cur_y)) &&
                 snap_q.vis;
    map_idx    = IDX_W'(cy_cur) * IDX_W'(GRID_W_MAX) + IDX_W'(cx_cur);
    alive_raw  = |(snap_q.map & (MAP_ONE << map_idx));

    s1_d.fs      = frame_top;
    s1_d.hs      = hs_raw;
    s1_d.vs      = vs_raw;
    s1_d.de      = de_raw;
    s1_d.win     = win_raw;
    s1_d.is_out  = ~in_grid;
    s1_d.edge_px = edge_x || edge_y;
    s1_d.cursor  = cursor_raw;
    s1_d.alive   = alive_raw;
  end

  always_comb begin
    rgb_d = COL_BLACK;
    if (!s1_q.de) begin
      rgb_d = COL_BLACK;
    end else if (s1_q.win) begin
      rgb_d = COL_FRAME;
    end else if (s1_q.is_out) begin
      rgb_d = COL_OUT;
    end else if (s1_q.edge_px && s1_q.cursor) begin
      rgb_d = COL_CURSOR;
    end else if (s1_q.edge_px) begin
      rgb_d = COL_FRAME;
    end else if (s1_q.alive) begin
      rgb_d = COL_ALIVE;
    end
    hs_d = s1_q.hs;
    vs_d = s1_q.vs;
    de_d = s1_q.de;
    fs_d = s1_q.fs;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_count_q    <= '0;
      v_count_q    <= '0;
      snap_q       <= '0;
      blink_cnt_q  <= '0;
      blink_hide_q <= 1'b0;
      px_x_q       <= '0;
      py_q         <= '0;
      cell_x_q     <= '0;
      cell_y_q     <= '0;
      s1_q         <= PIX_RESET;
      rgb_q        <= COL_BLACK;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      de_q         <= 1'b0;
      fs_q         <= 1'b0;
    end else begin
      h_count_q    <= h_count_d;
      v_count_q    <= v_count_d;
      snap_q       <= snap_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_hide_q <= blink_hide_d;
      px_x_q       <= px_x_d;
      py_q         <= py_d;
      cell_x_q     <= cell_x_d;
      cell_y_q     <= cell_y_d;
      s1_q         <= s1_d;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      de_q         <= de_d;
      fs_q         <= fs_d;
    end
  end

  assign frame_start = fs_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Self-checking bench for vga_grid_renderer: directed scenarios plus random frames,
// compared every cycle against an arithmetic (division-based) pixel model.
module tb_vga_grid_renderer;

  localparam int GWM   = 16;
  localparam int GHM   = 16;
  localparam int BRD   = 1;
  localparam int BLINK = 2;
  localparam int CW    = 12;

  localparam int H_TOTAL = 19, H_SYNC = 1, H_START = 4, H_END = 16;
  localparam int V_TOTAL = 19, V_SYNC = 1, V_START = 4, V_END = 16;
  localparam int FRAME_CYCLES = (H_TOTAL + 1) * (V_TOTAL + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [CW-1:0] h_total, h_sync, h_start, h_end;
  logic [CW-1:0] v_total, v_sync, v_start, v_end;
  logic [CW-1:0] cell_w, cell_h;
  logic [4:0] grid_w, grid_h;
  logic [GWM*GHM-1:0] cell_map;
  logic [3:0] cursor_x, cursor_y;
  logic frame_start, vga_hs, vga_vs, vga_de;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_grid_renderer #(
    .GRID_W_MAX(GWM), .GRID_H_MAX(GHM), .BORDER(BRD), .BLINK_FRAMES(BLINK), .CW(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
    .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
    .cell_w(cell_w), .cell_h(cell_h), .grid_w(grid_w), .grid_h(grid_h),
    .cell_map(cell_map), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .frame_start(frame_start), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state: beam position, frame-latched inputs, two-deep output delay.
  int hM, vM, frameIdx;
  logic [GWM*GHM-1:0] sMap;
  int sGw, sGh, sCw, sCh, sCx, sCy;
  bit sVis;
  logic [27:0] pipe1, pipe2;
  localparam logic [27:0] RESET_OUT = {1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};

  int cursorPixels, dePixels, outPixels, alivePixels;

  function automatic logic [27:0] pixelModel(input int h, input int v);
    logic fs, hs, vs, de;
    logic [23:0] rgb;
    int cx, cy, px, py;
    bit edgeP;
    fs = (h == 0) && (v == 0);
    hs = (h >= H_SYNC) && (h != H_TOTAL);
    vs = (v >= V_SYNC) && (v != V_TOTAL);
    de = (h >= H_START) && (h < H_END) && (v >= V_START) && (v < V_END);
    rgb = 24'h000000;
    if (de) begin
      if (h == H_START || h == H_END - 1 || v == V_START || v == V_END - 1) begin
        rgb = 24'h32D8E0;
      end else begin
        cx = (h - H_START) / sCw;
        px = (h - H_START) % sCw;
        cy = (v - V_START) / sCh;
        py = (v - V_START) % sCh;
        if (cx > GWM) cx = GWM;
        if (cy > GHM) cy = GHM;
        if (!(cx < sGw && cy < sGh)) begin
          rgb = 24'hFFFFFF;
        end else begin
          edgeP = (sCw <= 2 * BRD) || (px < BRD) || (px >= sCw - BRD) ||
                  (sCh <= 2 * BRD) || (py < BRD) || (py >= sCh - BRD);
          if (edgeP && cx == sCx && cy == sCy && sVis) rgb = 24'hFF5C39;
          else if (edgeP) rgb = 24'h32D8E0;
          else if (sMap[cy * GWM + cx]) rgb = 24'h12AFAF;
          else rgb = 24'h000000;
        end
      end
    end
    return {fs, hs, vs, de, rgb};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cwI, input int chI, input int gwI, input int ghI,
                               input int cxI, input int cyI, input logic [GWM*GHM-1:0] mapI);
    cell_w   = CW'(cwI);
    cell_h   = CW'(chI);
    grid_w   = 5'(gwI);
    grid_h   = 5'(ghI);
    cursor_x = 4'(cxI);
    cursor_y = 4'(cyI);
    cell_map = mapI;
  endtask

  function automatic logic [27:0] dutOut();
    return {frame_start, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b};
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    if (!reset_n) begin
      hM = 0; vM = 0; frameIdx = -1;
      sMap = '0; sGw = 0; sGh = 0; sCw = 1; sCh = 1; sCx = 0; sCy = 0; sVis = 1'b1;
      pipe1 = RESET_OUT;
      pipe2 = RESET_OUT;
    end else begin
      if (hM == 0 && vM == 0) begin
        frameIdx++;
        sMap = cell_map; sGw = int'(grid_w); sGh = int'(grid_h);
        sCw = int'(cell_w); sCh = int'(cell_h);
        sCx = int'(cursor_x); sCy = int'(cursor_y);
        sVis = ((frameIdx / BLINK) % 2) == 0;
      end
      pipe2 = pipe1;
      pipe1 = pixelModel(hM, vM);
      if (hM == H_TOTAL) begin
        hM = 0;
        vM = (vM == V_TOTAL) ? 0 : vM + 1;
      end else begin
        hM++;
      end
    end
    #1;
    checkOutput($sformatf("pixel f%0d", frameIdx), 32'(dutOut()), 32'(pipe2));
    if (vga_de) dePixels++;
    if ({vga_r, vga_g, vga_b} == 24'hFF5C39) cursorPixels++;
    if ({vga_r, vga_g, vga_b} == 24'hFFFFFF) outPixels++;
    if ({vga_r, vga_g, vga_b} == 24'h12AFAF) alivePixels++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic clearCounts();
    cursorPixels = 0; dePixels = 0; outPixels = 0; alivePixels = 0;
  endtask

  function automatic logic [GWM*GHM-1:0] randMap();
    logic [GWM*GHM-1:0] m;
    for (int i = 0; i < GWM * GHM / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  logic [GWM*GHM-1:0] mapA;

  initial begin
    h_total = CW'(H_TOTAL); h_sync = CW'(H_SYNC); h_start = CW'(H_START); h_end = CW'(H_END);
    v_total = CW'(V_TOTAL); v_sync = CW'(V_SYNC); v_start = CW'(V_START); v_end = CW'(V_END);
    mapA = '0;
    mapA[0] = 1'b1;
    applyStimulus(4, 4, 3, 3, 1, 0, mapA);
    clearCounts();

    reset_n = 1'b0;
    runCycles(3);
    checkOutput("reset_state", 32'(dutOut()), 32'(RESET_OUT));
    reset_n = 1'b1;

    // Frames 0-1: cursor visible, 8 cursor-coloured border pixels in cell (1,0).
    clearCounts();
    runCycles(FRAME_CYCLES);
    checkOutput("cursor_f0", 32'(cursorPixels), 32'd8);
    checkOutput("de_count_f0", 32'(dePixels), 32'd144);
    checkOutput("alive_f0", 32'(alivePixels), 32'd4);
    clearCounts();
    runCycles(FRAME_CYCLES);
    checkOutput("cursor_f1", 32'(cursorPixels), 32'd8);

    // Frame 2: cursor hidden; map change mid-frame must not appear until frame 3.
    clearCounts();
    runCycles(FRAME_CYCLES / 2);
    mapA[1] = 1'b1;
    applyStimulus(4, 4, 3, 3, 1, 0, mapA);
    runCycles(FRAME_CYCLES - FRAME_CYCLES / 2);
    checkOutput("cursor_f2", 32'(cursorPixels), 32'd0);
    checkOutput("alive_f2", 32'(alivePixels), 32'd4);
    clearCounts();
    runCycles(FRAME_CYCLES);
    checkOutput("cursor_f3", 32'(cursorPixels), 32'd0);
    checkOutput("alive_f3", 32'(alivePixels), 32'd8);

    // Frame 4: empty grid, all inner active pixels white.
    applyStimulus(4, 4, 0, 3, 1, 0, mapA);
    clearCounts();
    runCycles(FRAME_CYCLES);
    checkOutput("out_gridw0", 32'(outPixels), 32'd100);
    checkOutput("cursor_gridw0", 32'(cursorPixels), 32'd0);

    // Frame 5 (blink visible): cursor just outside the grid is never drawn.
    applyStimulus(4, 4, 3, 3, 3, 0, mapA);
    clearCounts();
    runCycles(FRAME_CYCLES);
    checkOutput("cursor_outside", 32'(cursorPixels), 32'd0);

    // Random frames with a random mid-frame input change.
    for (int f = 0; f < 8; f++) begin
      int first;
      applyStimulus($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(0, 6),
                    $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7), randMap());
      first = $urandom_range(1, FRAME_CYCLES - 1);
      runCycles(first);
      applyStimulus($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(0, 6),
                    $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7), randMap());
      runCycles(FRAME_CYCLES - first);
    end

    // Mid-line reset for one cycle, then restart from frame 0.
    applyStimulus(4, 4, 3, 3, 1, 0, mapA);
    runCycles(153);
    reset_n = 1'b0;
    stepCycle();
    checkOutput("midline_reset", 32'(dutOut()), 32'(RESET_OUT));
    reset_n = 1'b1;
    clearCounts();
    runCycles(FRAME_CYCLES);
    checkOutput("cursor_after_reset", 32'(cursorPixels), 32'd8);
    checkOutput("de_after_reset", 32'(dePixels), 32'd144);
    runCycles(FRAME_CYCLES);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
